fifo_ptr_sync: RTL and testbench

//  Receiving end of an async-fifo pointer crossing. Takes the Gray-code pointer

---
 rtl/fifo_ptr_sync_if.sv | 33 +++
 rtl/fifo_ptr_sync.sv | 115 +++++++++++
 tb/tb_fifo_ptr_sync.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fifo_ptr_sync_if.sv
// Pointer-crossing bundle for one side of an async fifo.
// The fifo control logic is the master and the fifo_ptr_sync instance is the slave.
interface fifo_ptr_sync_if #(
   parameter int unsigned AddrBits = 8
);
   logic [AddrBits:0] local_pbin_nxt;
   logic [AddrBits:0] remote_pgray;
   logic [AddrBits:0] remote_pbin;
   logic              flag;
   logic              almost;
   logic [AddrBits:0] level;
   logic              gray_err;

   modport master (
      output local_pbin_nxt,
      output remote_pgray,
      input  remote_pbin,
      input  flag,
      input  almost,
      input  level,
      input  gray_err
   );

   modport slave (
      input  local_pbin_nxt,
      input  remote_pgray,
      output remote_pbin,
      output flag,
      output almost,
      output level,
      output gray_err
   );
endinterface

// File: rtl/fifo_ptr_sync.sv
// fifo_ptr_sync: receiving end of an async-fifo pointer crossing.
// Synchronises the remote Gray pointer, converts it to binary, and produces
// registered full/empty, almost and level status against the local pointer.
// WriteSide=1 reports full/free words; WriteSide=0 reports empty/used words.
// Optional feature macro: FIFO_PTR_SYNC_GRAY_CHECK_EN adds a sticky gray_err
// that flags any multi-bit step of the synchronised Gray pointer.
module fifo_ptr_sync #(
   parameter int unsigned AddrBits     = 8,
   parameter bit          WriteSide    = 1'b1,
   parameter int unsigned SyncStages   = 2,
   parameter int unsigned AlmostThresh = 4
) (
   input logic            clk,
   input logic            rst,
   fifo_ptr_sync_if.slave bus
);

   localparam int unsigned   PW     = AddrBits + 1;
   localparam logic [PW-1:0] Depth  = {1'b1, {AddrBits{1'b0}}};
   localparam logic [PW-1:0] Thresh = PW'(AlmostThresh);

   logic [PW-1:0] sy [SyncStages];
   logic [PW-1:0] sy_last;
   logic [PW-1:0] rb;
   logic [PW-1:0] used;
   logic [PW-1:0] level_nxt;
   logic          flag_nxt;
   logic          almost_nxt;

   // Synchroniser chain for the asynchronous remote Gray pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < SyncStages; i++) begin
            sy[i] <= '0;
         end
      end else begin
         sy[0] <= bus.remote_pgray;
         for (int unsigned i = 1; i < SyncStages; i++) begin
            sy[i] <= sy[i-1];
         end
      end
   end

   assign sy_last = sy[SyncStages-1];

   // Gray to binary: bit i is the XOR of Gray bits i..MSB.
   always_comb begin
      rb = '0;
      for (int unsigned i = 0; i < PW; i++) begin
         rb[i] = ^(sy_last >> i);
      end
   end

   // Next-state status; modulo 2**PW arithmetic handles pointer wrap.
   always_comb begin
      used      = '0;
      level_nxt = '0;
      flag_nxt  = 1'b0;
      if (WriteSide) begin
         used      = bus.local_pbin_nxt - rb;
         level_nxt = Depth - used;
         flag_nxt  = (used == Depth);
      end else begin
         used      = rb - bus.local_pbin_nxt;
         level_nxt = used;
         flag_nxt  = (used == '0);
      end
      almost_nxt = (level_nxt <= Thresh);
   end

   // Registered status outputs with side-dependent reset values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.remote_pbin <= '0;
         bus.flag        <= !WriteSide;
         bus.almost      <= !WriteSide;
         bus.level       <= WriteSide ? Depth : '0;
      end else begin
         bus.remote_pbin <= rb;
         bus.flag        <= flag_nxt;
         bus.almost      <= almost_nxt;
         bus.level       <= level_nxt;
      end
   end

`ifdef FIFO_PTR_SYNC_GRAY_CHECK_EN
   logic [PW-1:0] sy_prev;
   logic [PW-1:0] gdiff;
   logic          multi_bit;
   logic          gray_err_q;

   always_comb begin
      gdiff     = sy_last ^ sy_prev;
      multi_bit = ((gdiff & (gdiff - PW'(1))) != '0);
   end

   // Track the previous synchronised Gray value; latch any multi-bit step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sy_prev    <= '0;
         gray_err_q <= 1'b0;
      end else begin
         sy_prev <= sy_last;
         if (multi_bit) begin
            gray_err_q <= 1'b1;
         end
      end
   end

   assign bus.gray_err = gray_err_q;
`else
   assign bus.gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ptr_sync.sv
// Directed bench for fifo_ptr_sync: one write-side and one read-side instance,
// AddrBits=3, SyncStages=2, AlmostThresh=2. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_fifo_ptr_sync;

`ifdef FIFO_PTR_SYNC_GRAY_CHECK_EN
   localparam logic GrayChk = 1'b1;
`else
   localparam logic GrayChk = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   fifo_ptr_sync_if #(.AddrBits(3)) wr_if ();
   fifo_ptr_sync_if #(.AddrBits(3)) rd_if ();

   fifo_ptr_sync #(
      .AddrBits(3), .WriteSide(1'b1), .SyncStages(2), .AlmostThresh(2)
   ) u_wr (
      .clk(clk), .rst(rst), .bus(wr_if.slave)
   );

   fifo_ptr_sync #(
      .AddrBits(3), .WriteSide(1'b0), .SyncStages(2), .AlmostThresh(2)
   ) u_rd (
      .clk(clk), .rst(rst), .bus(rd_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      wr_if.local_pbin_nxt = '0;
      wr_if.remote_pgray   = '0;
      rd_if.local_pbin_nxt = '0;
      rd_if.remote_pgray   = '0;

      // 1: reset before any clock edge
      #1 rst = 1'b1;
      #1;
      check_val("rst_rd_flag",   32'(rd_if.flag),        1);
      check_val("rst_rd_almost", 32'(rd_if.almost),      1);
      check_val("rst_rd_level",  32'(rd_if.level),       0);
      check_val("rst_rd_rpbin",  32'(rd_if.remote_pbin), 0);
      check_val("rst_rd_gerr",   32'(rd_if.gray_err),    0);
      check_val("rst_wr_flag",   32'(wr_if.flag),        0);
      check_val("rst_wr_almost", 32'(wr_if.almost),      0);
      check_val("rst_wr_level",  32'(wr_if.level),       8);
      check_val("rst_wr_gerr",   32'(wr_if.gray_err),    0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("idle_wr_level", 32'(wr_if.level), 8);
      check_val("idle_rd_flag",  32'(rd_if.flag),  1);

      // 2: read-side latency, remote bin 3 (gray 0010)
      rd_if.remote_pgray = 4'b0010;
      @(negedge clk);                       // after edge N
      @(negedge clk);                       // after edge N+1
      check_val("lat_n1_rpbin", 32'(rd_if.remote_pbin), 0);
      check_val("lat_n1_flag",  32'(rd_if.flag),        1);
      @(negedge clk);                       // after edge N+2
      check_val("lat_n2_rpbin",  32'(rd_if.remote_pbin), 3);
      check_val("lat_n2_flag",   32'(rd_if.flag),        0);
      check_val("lat_n2_level",  32'(rd_if.level),       3);
      check_val("lat_n2_almost", 32'(rd_if.almost),      0);

      // 3: write side full, then one free
      wr_if.local_pbin_nxt = 4'b1000;
      @(negedge clk);
      check_val("full_flag",   32'(wr_if.flag),   1);
      check_val("full_level",  32'(wr_if.level),  0);
      check_val("full_almost", 32'(wr_if.almost), 1);
      wr_if.local_pbin_nxt = 4'd7;
      @(negedge clk);
      check_val("free1_flag",   32'(wr_if.flag),   0);
      check_val("free1_level",  32'(wr_if.level),  1);
      check_val("free1_almost", 32'(wr_if.almost), 1);

      // 4: wrap, local 2 against remote bin 10 then 11
      wr_if.local_pbin_nxt = 4'b0010;
      wr_if.remote_pgray   = 4'b1111;
      repeat (3) @(negedge clk);
      check_val("wrap_rpbin", 32'(wr_if.remote_pbin), 10);
      check_val("wrap_flag",  32'(wr_if.flag),        1);
      check_val("wrap_level", 32'(wr_if.level),       0);
      wr_if.remote_pgray = 4'b1110;
      repeat (3) @(negedge clk);
      check_val("wrap11_flag",   32'(wr_if.flag),   0);
      check_val("wrap11_level",  32'(wr_if.level),  1);
      check_val("wrap11_almost", 32'(wr_if.almost), 1);

      // 6: reset between edges while full
      wr_if.local_pbin_nxt = 4'b1000;
      wr_if.remote_pgray   = 4'b0000;
      rd_if.remote_pgray   = 4'b0000;
      repeat (3) @(negedge clk);
      check_val("pre_rst_flag", 32'(wr_if.flag), 1);
      #2 rst = 1'b1;
      #1;
      check_val("mid_rst_flag",  32'(wr_if.flag),     0);
      check_val("mid_rst_level", 32'(wr_if.level),    8);
      check_val("mid_rst_gerr",  32'(wr_if.gray_err), 0);
      wr_if.local_pbin_nxt = 4'd3;
      @(negedge clk);
      check_val("hold_rst_flag",  32'(wr_if.flag),  0);
      check_val("hold_rst_level", 32'(wr_if.level), 8);
      wr_if.local_pbin_nxt = 4'b1000;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rel_no_edge_flag", 32'(wr_if.flag), 0);
      @(negedge clk);
      check_val("rel_edge1_flag",  32'(wr_if.flag),  1);
      check_val("rel_edge1_level", 32'(wr_if.level), 0);

      // 5: Gray coherence, 0000 -> 0011 on the read side
      rd_if.remote_pgray = 4'b0011;
      @(negedge clk);                       // after edge N
      @(negedge clk);                       // after edge N+1
      check_val("gerr_n1", 32'(rd_if.gray_err), 0);
      @(negedge clk);                       // after edge N+2
      check_val("gerr_n2",     32'(rd_if.gray_err), 32'(GrayChk));
      check_val("gerr_level",  32'(rd_if.level),    2);
      check_val("gerr_almost", 32'(rd_if.almost),   1);
      rd_if.remote_pgray = 4'b0010;
      repeat (4) @(negedge clk);
      check_val("gerr_sticky", 32'(rd_if.gray_err), 32'(GrayChk));
      #2 rst = 1'b1;
      #1;
      check_val("gerr_cleared", 32'(rd_if.gray_err), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
